// File: rtl/lrc_pkg.sv
// rtl/lrc_pkg.sv - shared types and constants for the LRC frame controller
//
// Purpose: FSM state encoding, GEN/CHECK mode encoding, the LRC mask constant
// and the two's-complement finalize helper used by lrc_accum.
// Ports: none (package).

package lrc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } lrc_state_e;

    typedef enum logic {
        MODE_GEN   = 1'b0,
        MODE_CHECK = 1'b1
    } lrc_mode_e;

    localparam logic [7:0] LRC_MASK = 8'hFF;

    // LRC is the two's complement of the byte sum, so that sum + LRC == 0 mod 256.
    function automatic logic [7:0] lrc_finalize(input logic [7:0] sum);
        return (sum ^ LRC_MASK) + 8'd1;
    endfunction

endpackage

// File: rtl/lrc_frame_ctrl_if.sv
// rtl/lrc_frame_ctrl_if.sv - frame request, byte stream and result bundle
//
// Purpose: groups the control, byte-stream and result handshakes of
// lrc_frame_ctrl. clk/rst are not part of the bundle.
// Signals:
//   start/mode/len/abort       frame request and cancel
//   in_valid/in_data/in_ready  byte stream into the controller
//   out_valid/out_lrc/out_ok   result, held until out_ready
//   busy/byte_count            status
// Modports: master = frame source / result consumer, slave = controller.

interface lrc_frame_ctrl_if #(
    parameter int LEN_W = 8
) ();

    logic             start;
    logic             mode;
    logic [LEN_W-1:0] len;
    logic             abort;

    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;

    logic             out_valid;
    logic [7:0]       out_lrc;
    logic             out_ok;
    logic             out_ready;

    logic             busy;
    logic [LEN_W:0]   byte_count;

    modport master (
        output start, mode, len, abort,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_lrc, out_ok,
        output out_ready,
        input  busy, byte_count
    );

    modport slave (
        input  start, mode, len, abort,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_lrc, out_ok,
        input  out_ready,
        output busy, byte_count
    );

endinterface

// File: rtl/lrc_accum.sv
// rtl/lrc_accum.sv - 8-bit modulo-256 byte sum with finalize output
//
// Purpose: holds the running byte sum of a frame.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        clear the sum (takes priority over en)
//   en, data   add data to the sum this cycle
//   sum        current sum
//   fin        two's complement of the current sum (the GEN-mode LRC)

module lrc_accum
    import lrc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] sum,
    output logic [7:0] fin
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = 8'h00;
        end else if (en) begin
            sum_d = sum_q + data;   // 8-bit result wraps mod 256
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
    assign fin = lrc_finalize(sum_q);

endmodule

// File: rtl/lrc_frame_ctrl.sv
// rtl/lrc_frame_ctrl.sv - LRC generate/check frame controller
//
// Purpose: accepts a frame request (mode, len), sums len payload bytes (GEN)
// or len payload bytes plus the trailing LRC byte (CHECK), then presents the
// LRC or the residual on a held result handshake.
// Ports:
//   clk   single clock
//   rst   synchronous active-high reset
//   bus   lrc_frame_ctrl_if slave modport (request, byte stream, result, status)

module lrc_frame_ctrl
    import lrc_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    lrc_frame_ctrl_if.slave  bus
);

    lrc_state_e       state_q, state_d;
    logic [LEN_W-1:0] len_q,   len_d;
    lrc_mode_e        mode_q,  mode_d;
    logic [LEN_W:0]   cnt_q,   cnt_d;

    logic             acc_clr;
    logic             acc_en;
    logic [7:0]       acc_sum;
    logic [7:0]       acc_fin;

    logic             in_ready;
    logic             accept;
    logic [LEN_W:0]   cnt_inc;
    logic [LEN_W:0]   target;

    // abort gates in_ready so an abort cycle never accepts a byte
    assign in_ready = (state_q == ACCUM) && !bus.abort;
    assign accept   = bus.in_valid && in_ready;
    assign cnt_inc  = cnt_q + {{LEN_W{1'b0}}, 1'b1};

    // CHECK also consumes the trailing LRC byte; one extra bit keeps len+1 exact
    assign target   = {1'b0, len_q} + {{LEN_W{1'b0}}, (mode_q == MODE_CHECK)};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d   = bus.len;
                    mode_d  = lrc_mode_e'(bus.mode);
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                    // an empty GEN frame has nothing to accumulate
                    if ((bus.len == '0) && (bus.mode == MODE_GEN)) begin
                        state_d = RESULT;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end

            ACCUM: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    acc_en = 1'b1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == target) begin
                        state_d = RESULT;
                    end
                end
            end

            RESULT: begin
                if (bus.abort || bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            mode_q  <= MODE_GEN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    lrc_accum u_accum (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .en   (acc_en),
        .data (bus.in_data),
        .sum  (acc_sum),
        .fin  (acc_fin)
    );

    // Result outputs decode only flops: the sum is frozen in RESULT, so they
    // hold steady for as long as out_ready stays low.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_lrc   = 8'h00;
        bus.out_ok    = 1'b0;
        if (state_q == RESULT) begin
            bus.out_valid = 1'b1;
            if (mode_q == MODE_CHECK) begin
                bus.out_lrc = acc_sum;
                bus.out_ok  = (acc_sum == 8'h00);
            end else begin
                bus.out_lrc = acc_fin;
                bus.out_ok  = 1'b1;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.busy       = (state_q != IDLE);
    assign bus.byte_count = cnt_q;

endmodule

// File: tb/tb_lrc_frame_ctrl.sv
// tb/tb_lrc_frame_ctrl.sv - scoreboard bench for lrc_frame_ctrl

module tb_lrc_frame_ctrl;

    localparam int LEN_W = 8;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] lrc;
        logic       ok;
        int         cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lrc_frame_ctrl_if #(.LEN_W(LEN_W)) bus ();

    lrc_frame_ctrl #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor: result stability and scoreboard ----------------
    logic [7:0] prev_lrc;
    logic       prev_ok;
    bit         prev_hold = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold <= 1'b0;
        end else if (bus.out_valid) begin
            if (prev_hold) begin
                chk("hold_out_lrc", bus.out_lrc, prev_lrc);
                chk("hold_out_ok", bus.out_ok, prev_ok);
            end
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: lrc=0x%0h with no frame outstanding", bus.out_lrc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_lrc", bus.out_lrc, mon_e.lrc);
                    chk("out_ok", bus.out_ok, mon_e.ok);
                    chk("byte_count", bus.byte_count, mon_e.cnt);
                end
                prev_hold <= 1'b0;
            end else begin
                prev_hold <= 1'b1;
                prev_lrc  <= bus.out_lrc;
                prev_ok   <= bus.out_ok;
            end
        end else begin
            prev_hold <= 1'b0;
        end
    end

    // ---------------- reference model ----------------
    // GEN: LRC is whatever makes the byte total a multiple of 256.
    // CHECK: residual is the byte total mod 256; pass when it is zero.
    function automatic exp_t model(input bit m, input bq_t q);
        exp_t e;
        int   s = 0;
        foreach (q[i]) s += int'(q[i]);
        s = s % 256;
        if (m == 1'b0) begin
            e.lrc = 8'((256 - s) % 256);
            e.ok  = 1'b1;
        end else begin
            e.lrc = 8'(s);
            e.ok  = (s == 0);
        end
        e.cnt = q.size();
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input bit m, input int l);
        tick();
        bus.start = 1'b1;
        bus.mode  = m;
        bus.len   = l[LEN_W-1:0];
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_one(input logic [7:0] d, input bit gap);
        int t   = 0;
        bit acc = 1'b0;
        if (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            t++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: byte 0x%0h not accepted within 50 cycles", d);
        end
    endtask

    task automatic finish_result(input int hold, input bit poke_start);
        tick();
        for (int i = 0; i < hold; i++) begin
            if (poke_start) begin
                bus.start = 1'b1;
                bus.mode  = ~bus.mode;
                bus.len   = 8'd5;
            end
            tick();
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_handshake_busy", bus.busy, 1'b0);
        chk("idle_after_handshake_valid", bus.out_valid, 1'b0);
    endtask

    task automatic run_frame(input bit m, input int l, input bq_t q,
                             input bit gaps, input int hold, input bit poke);
        exp_q.push_back(model(m, q));
        start_frame(m, l);
        foreach (q[i]) send_one(q[i], gaps);
        @(negedge clk);
        chk("result_latency", bus.out_valid, 1'b1);
        finish_result(hold, poke);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bq_t q;
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.len       = '0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        rst           = 1'b1;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_lrc", bus.out_lrc, 8'h00);
        chk("rst_out_ok", bus.out_ok, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_byte_count", bus.byte_count, 0);
        rst = 1'b0;

        // in_valid while idle is ignored
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        tick();
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_byte_count", bus.byte_count, 0);
        bus.in_valid = 1'b0;

        q = {8'h01, 8'h02, 8'h03};
        run_frame(1'b0, 3, q, 1'b0, 0, 1'b0);
        q = {8'h01, 8'h02, 8'h03, 8'hFA};
        run_frame(1'b1, 3, q, 1'b0, 1, 1'b0);
        q = {8'h01, 8'h02, 8'h03, 8'hFB};
        run_frame(1'b1, 3, q, 1'b0, 0, 1'b0);
        q = {8'hFF, 8'h02};
        run_frame(1'b0, 2, q, 1'b1, 0, 1'b0);
        q = {8'h00, 8'h00};
        run_frame(1'b0, 2, q, 1'b0, 0, 1'b0);
        q = {};
        run_frame(1'b0, 0, q, 1'b0, 0, 1'b0);
        q = {8'h00};
        run_frame(1'b1, 0, q, 1'b0, 0, 1'b0);

        // held result with start pokes while out_ready is low
        q = {8'h10, 8'h20, 8'h30};
        run_frame(1'b0, 3, q, 1'b0, 5, 1'b1);

        // abort during the second byte, then a clean frame from sum 0
        start_frame(1'b0, 3);
        send_one(8'h11, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h22;
        bus.abort    = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", bus.in_ready, 1'b0);
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_byte_count", bus.byte_count, 1);
        q = {8'h05};
        run_frame(1'b0, 1, q, 1'b0, 0, 1'b0);

        // reset mid-frame wins over start and abort
        start_frame(1'b1, 4);
        send_one(8'h33, 1'b0);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_byte_count", bus.byte_count, 0);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // longest CHECK frame: byte_count reaches 2^LEN_W
        q = {};
        for (int i = 0; i < 255; i++) q.push_back(8'($urandom));
        q.push_back(model(1'b0, q).lrc);
        run_frame(1'b1, 255, q, 1'b0, 0, 1'b0);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            bit m;
            int l;
            m = 1'($urandom_range(0, 1));
            l = $urandom_range(0, 8);
            q = {};
            for (int i = 0; i < l; i++) q.push_back(8'($urandom));
            if (m) begin
                if ($urandom_range(0, 1) == 1) q.push_back(model(1'b0, q).lrc);
                else q.push_back(8'($urandom));
            end
            run_frame(m, l, q, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        repeat (2) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lrc_frame_ctrl.md
LRC_FRAME_CTRL -- requirements
Module: lrc_frame_ctrl

Interface
REQ-001 Parameter LEN_W, default 8: width of the frame-length input.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  frame-start request; sampled only in IDLE.
REQ-005 Port: mode  input  1  0 = GEN (produce LRC), 1 = CHECK (verify trailing LRC byte); sampled with start.
REQ-006 Port: len  input  LEN_W  payload byte count; sampled with start; 0 is legal.
REQ-007 Port: abort  input  1  cancels the frame in progress.
REQ-008 Port: in_valid / in_data  input  1 / 8  byte stream from the source.
REQ-009 Port: in_ready  output  1  controller accepts a byte this cycle.
REQ-010 Port: out_valid / out_lrc / out_ok  output  1 / 8 / 1  result, LRC or residual, and check pass flag.
REQ-011 Port: out_ready  input  1  result consumer handshake.
REQ-012 Port: busy  output  1  high in any state other than IDLE.
REQ-013 Port: byte_count  output  LEN_W+1  bytes accepted in the current frame.

Function
REQ-014 FSM states: IDLE, ACCUM, RESULT.
REQ-015 IDLE with start=1 SHALL latch len and mode, clear sum and byte_count, and go to ACCUM next cycle; if len=0 and mode=GEN, it SHALL go directly to RESULT.
REQ-016 Start outside IDLE SHALL be ignored.
REQ-017 in_ready SHALL be 1 only in ACCUM with abort=0.
REQ-018 A byte SHALL be accepted only when in_valid and in_ready are both 1; on acceptance, sum <= (sum + in_data) mod 256 and byte_count increments.
REQ-019 Bytes equal to 0x00 and repeated equal bytes SHALL be accepted and counted like any other byte; there is no change detection.
REQ-020 Target count SHALL be len in GEN and len+1 in CHECK, including the trailing LRC byte; byte_count is LEN_W+1 bits wide so 2^LEN_W is representable.
REQ-021 When the byte that reaches the target count is accepted in cycle t, the FSM SHALL enter RESULT with out_valid=1 in cycle t+1.
REQ-022 In RESULT, GEN mode: out_lrc = ((sum XOR 0xFF) + 1) mod 256 and out_ok = 1.
REQ-023 In RESULT, CHECK mode: out_lrc = sum and out_ok = (sum == 0x00).
REQ-024 out_valid, out_lrc and out_ok SHALL hold stable until out_ready=1; on that handshake the FSM SHALL return to IDLE next cycle, and out_valid SHALL drop.
REQ-025 abort=1 in ACCUM or RESULT SHALL return the FSM to IDLE next cycle with no result handshake.
REQ-026 Abort together with in_valid SHALL win: the byte is not accepted and sum and count are unchanged.
REQ-027 In IDLE, in_valid SHALL be ignored and in_ready SHALL stay 0.

Reset
REQ-028 With rst=1 at a clock edge, the FSM SHALL go to IDLE and sum, byte_count, latched len and mode SHALL be cleared.
REQ-029 Reset values: in_ready=0, out_valid=0, out_lrc=0x00, out_ok=0, busy=0.
REQ-030 Reset mid-frame SHALL discard the frame; rst has priority over start and abort.

Structure
REQ-031 Shared package lrc_pkg SHALL hold the state enum (IDLE/ACCUM/RESULT), the mode encodings (GEN=0, CHECK=1) and the constant LRC_MASK=8'hFF.
REQ-032 One sub-module, lrc_accum, SHALL hold the 8-bit sum register with clear/enable/data inputs and a finalize output; the FSM, counter and handshakes SHALL stay in lrc_frame_ctrl.

Verification
REQ-033 GEN, len=3, bytes 0x01,0x02,0x03 -> out_lrc=0xFA, out_ok=1, out_valid the cycle after the third accept.
REQ-034 CHECK, len=3, bytes 0x01,0x02,0x03,0xFA -> out_lrc=0x00, out_ok=1; same with last byte 0xFB -> out_lrc=0x01, out_ok=0.
REQ-035 GEN, len=2, bytes 0xFF,0x02 with in_valid toggled every other cycle -> wrap-around gives sum 0x01, out_lrc=0xFF, byte_count=2.
REQ-036 GEN, len=2, bytes 0x00,0x00 -> both accepted, out_lrc=0x00; separately, GEN len=0 -> out_valid=1 the cycle after start with out_lrc=0x00.
REQ-037 out_ready held 0 for 5 cycles in RESULT -> outputs stable and start ignored; then out_ready=1 -> IDLE next cycle.
REQ-038 Abort with in_valid during the second of three bytes -> IDLE next cycle, no out_valid; a following frame computes from sum 0x00.
